mc_divider: RTL and testbench
=============================

MC_DIVIDER -- requirements
Module: mc_divider

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 64, the operand and result width in bits.
REQ-002 SHALL have parameter DIV_OP_WIDTH, default 2, the width of the op select.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  request strobe from the EX stage, sampled only in IDLE.
REQ-006 op  input  DIV_OP_WIDTH  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 dividend  input  BUS_WIDTH  in1 operand, captured when start is accepted.
REQ-008 divisor  input  BUS_WIDTH  in2 operand, captured when start is accepted.
REQ-009 busy  output  1  high while an operation is in flight, from CALC through FIX.
REQ-010 stall  output  1  combinational EX stall request.
REQ-011 done  output  1  one-cycle pulse; result is valid in this cycle.
REQ-012 result  output  BUS_WIDTH  quotient or remainder, held until the next accepted start.

Function
REQ-013 SHALL have four states: IDLE, CALC, FIX and DONE.
REQ-014 In IDLE with start=1, SHALL capture op, the operand magnitudes and the operand signs.
- Signed ops (DIV, REM): magnitudes are the two's-complement absolute values.
- Unsigned ops (DIVU, REMU): operands are taken as-is.
REQ-015 Special cases SHALL be detected at acceptance, and the block SHALL go IDLE->DONE in one cycle with these results:
- divisor=0: quotient = all ones; remainder = dividend.
- Signed ops, dividend = most-negative value and divisor = -1: quotient = dividend; remainder = 0.
REQ-016 Normal case: IDLE->CALC, with remainder register cleared and iteration counter = 0.
REQ-017 CALC SHALL do one restoring radix-2 step per cycle:
- Shift {rem, quo} left by 1.
- Trial-subtract the divisor magnitude using BUS_WIDTH+1-bit arithmetic.
- If the difference is non-negative, keep it and set the quotient LSB to 1.
REQ-018 CALC SHALL last exactly BUS_WIDTH cycles; counter = BUS_WIDTH-1 SHALL transition to FIX.
REQ-019 FIX SHALL apply signs for signed ops only:
- Quotient is negated if the dividend sign XOR the divisor sign is 1.
- Remainder is negated if the dividend sign is 1.
REQ-019a FIX SHALL select quotient (DIV/DIVU) or remainder (REM/REMU) into result, then go to DONE.
REQ-020 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-021 Latency from the accepting edge T:
- Normal: done high in cycle T+BUS_WIDTH+2 (66 for BUS_WIDTH=64).
- Special case: done high in cycle T+1.
REQ-022 A start received in IDLE during the DONE cycle SHALL NOT be accepted.
REQ-022a A new operation is accepted only in IDLE.
REQ-022b back-to-back ops SHALL therefore have at least one IDLE cycle between them.
REQ-023 start and operand changes while not in IDLE SHALL be ignored.
REQ-024 busy SHALL be 1 in CALC and FIX, and 0 in IDLE and DONE.
REQ-025 stall SHALL equal (IDLE and start and not special case) OR busy.
- The EX stage therefore freezes from the request cycle through FIX.
- stall is 0 in DONE, so the result is written back that cycle.
REQ-026 result SHALL change only on the transition into DONE.

Reset
REQ-027 rst=1 SHALL force the following within the same cycle, independent of clk:
- state = IDLE
- busy, done, stall(registered terms) = 0
- result = 0
- counter = 0
- internal registers = 0
REQ-028 Reset mid-operation SHALL abort the division with no done pulse; the next start after reset release SHALL work normally.

Verification
REQ-029 Scenario DIVU: 100 / 7.
- result = 14.
- done exactly 66 cycles after the accepting edge.
- busy high for 65 cycles.
REQ-030 Scenario signed: DIV -100 / 7 = -14; REM -100 / 7 = -2; REM 100 / -7 = 2.
REQ-031 Scenario divide-by-zero: DIVU 5 / 0 = 0xFFFF_FFFF_FFFF_FFFF; REMU 5 / 0 = 5; done at T+1; stall never high.
REQ-032 Scenario overflow: DIV 0x8000_0000_0000_0000 / -1 = 0x8000_0000_0000_0000; REM of the same = 0; done at T+1.
REQ-033 Scenario ignore/hold:
- start pulsed and operands changed during CALC produce no effect; result is from the original operands.
- A start in the DONE cycle is not accepted.
REQ-034 Scenario reset mid-op: assert rst at cycle 30 of CALC.
- All outputs drop to 0 immediately; no done pulse.
- A subsequent REMU 0xFFFF_FFFF_FFFF_FFFF / 0x10 = 0xF.

Source files
------------

// File: rtl/mc_divider.sv
// ============================================================================
// Module   : mc_divider
// Brief    : Multi-cycle restoring radix-2 divider (DIV/DIVU/REM/REMU).
// Revision : 1.0
// ============================================================================
`default_nettype none

module mc_divider #(
  parameter int BUS_WIDTH    = 64,
  parameter int DIV_OP_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DIV_OP_WIDTH-1:0] op,
  input  logic [BUS_WIDTH-1:0]    dividend,
  input  logic [BUS_WIDTH-1:0]    divisor,
  output logic                    busy,
  output logic                    stall,
  output logic                    done,
  output logic [BUS_WIDTH-1:0]    result
);

  localparam int                  CNT_W    = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(BUS_WIDTH - 1);
  localparam logic [BUS_WIDTH-1:0] MOST_NEG = {1'b1, {(BUS_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0] quo_q, quo_d;
  logic [BUS_WIDTH-1:0] rem_q, rem_d;
  logic [BUS_WIDTH-1:0] dvs_q, dvs_d;
  logic                 sign_dd_q, sign_dd_d;
  logic                 sign_dv_q, sign_dv_d;
  logic                 is_rem_q, is_rem_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [BUS_WIDTH-1:0] result_q, result_d;

  // op[0] selects unsigned, op[1] selects remainder
  logic                 w_signed_op;
  logic                 w_dd_neg;
  logic                 w_dv_neg;
  logic [BUS_WIDTH-1:0] w_dd_mag;
  logic [BUS_WIDTH-1:0] w_dv_mag;
  logic                 w_div_zero;
  logic                 w_ovf;
  logic                 w_special;
  logic [BUS_WIDTH-1:0] w_special_res;
  logic [BUS_WIDTH:0]   w_rem_wide;
  logic [BUS_WIDTH:0]   w_diff;
  logic [BUS_WIDTH-1:0] w_quo_fix;
  logic [BUS_WIDTH-1:0] w_rem_fix;

  always_comb begin
    w_signed_op = ~op[0];
    w_dd_neg    = w_signed_op & dividend[BUS_WIDTH-1];
    w_dv_neg    = w_signed_op & divisor[BUS_WIDTH-1];
    w_dd_mag    = w_dd_neg ? ('0 - dividend) : dividend;
    w_dv_mag    = w_dv_neg ? ('0 - divisor) : divisor;
    w_div_zero  = (divisor == '0);
    w_ovf       = w_signed_op & (dividend == MOST_NEG) & (divisor == '1);
    w_special   = w_div_zero | w_ovf;
    if (w_div_zero) begin
      w_special_res = op[1] ? dividend : '1;
    end else begin
      w_special_res = op[1] ? '0 : dividend;
    end

    // Shifted partial remainder needs one extra bit before the trial subtract
    w_rem_wide = {rem_q, quo_q[BUS_WIDTH-1]};
    w_diff     = w_rem_wide - {1'b0, dvs_q};

    // Sign flags are only ever set for signed ops, so no op check is needed here
    w_quo_fix  = (sign_dd_q ^ sign_dv_q) ? ('0 - quo_q) : quo_q;
    w_rem_fix  = sign_dd_q ? ('0 - rem_q) : rem_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    sign_dd_d = sign_dd_q;
    sign_dv_d = sign_dv_q;
    is_rem_d  = is_rem_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          is_rem_d  = op[1];
          sign_dd_d = w_dd_neg;
          sign_dv_d = w_dv_neg;
          quo_d     = w_dd_mag;
          dvs_d     = w_dv_mag;
          rem_d     = '0;
          cnt_d     = '0;
          if (w_special) begin
            result_d = w_special_res;
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            busy_d  = 1'b1;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (!w_diff[BUS_WIDTH]) begin
          rem_d = w_diff[BUS_WIDTH-1:0];
          quo_d = {quo_q[BUS_WIDTH-2:0], 1'b1};
        end else begin
          rem_d = w_rem_wide[BUS_WIDTH-1:0];
          quo_d = {quo_q[BUS_WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = FIX;
        end
      end
      FIX: begin
        result_d = is_rem_q ? w_rem_fix : w_quo_fix;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      sign_dd_q <= 1'b0;
      sign_dv_q <= 1'b0;
      is_rem_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      sign_dd_q <= sign_dd_d;
      sign_dv_q <= sign_dv_d;
      is_rem_q  <= is_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  // Freeze EX from the request cycle; special cases finish without stalling
  assign stall  = ((state_q == IDLE) & start & ~w_special) | busy_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_mc_divider.sv
// ============================================================================
// Module   : tb_mc_divider
// Brief    : Self-checking bench for mc_divider against an arithmetic model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mc_divider;

  localparam int          W        = 64;
  localparam logic [63:0] MOST_NEG = 64'h8000_0000_0000_0000;
  localparam logic [1:0]  OP_DIV   = 2'b00;
  localparam logic [1:0]  OP_DIVU  = 2'b01;
  localparam logic [1:0]  OP_REM   = 2'b10;
  localparam logic [1:0]  OP_REMU  = 2'b11;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  dividend;
  logic [W-1:0]  divisor;
  logic          busy;
  logic          stall;
  logic          done;
  logic [W-1:0]  result;

  int n_checks;
  int n_errors;

  mc_divider #(.BUS_WIDTH(W), .DIV_OP_WIDTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
    longint sa;
    longint sb;
    sa = longint'(a);
    sb = longint'(b);
    if (b == 64'd0) return o[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    if (!o[0] && a == MOST_NEG && b == 64'hFFFF_FFFF_FFFF_FFFF) return o[1] ? 64'd0 : a;
    case (o)
      OP_DIV:  return 64'(sa / sb);
      OP_DIVU: return a / b;
      OP_REM:  return 64'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
    return (b == 64'd0) || (!o[0] && a == MOST_NEG && b == 64'hFFFF_FFFF_FFFF_FFFF);
  endfunction

  // disturb: poke start/operands mid-CALC and request again in the DONE cycle
  task automatic run_op(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b, input bit disturb);
    logic [63:0] exp_r;
    bit          spec;
    bit          got;
    int          lat;
    int          busy_n;
    int          stall_n;
    exp_r = model(o, a, b);
    spec  = is_special(o, a, b);
    @(negedge clk);
    start = 1'b1; op = o; dividend = a; divisor = b;
    #1;
    check("req_stall", 64'(stall), 64'(!spec));
    @(posedge clk);
    #1 start = 1'b0;
    got = 1'b0; lat = 0; busy_n = 0; stall_n = 0;
    for (int k = 1; k <= 200 && !got; k++) begin
      @(negedge clk);
      busy_n  += int'(busy);
      stall_n += int'(stall);
      if (done) begin
        got = 1'b1;
        lat = k;
        check("done_stall", 64'(stall), 64'd0);
      end
      if (disturb && k == 10) begin
        start = 1'b1; op = ~o; dividend = ~a; divisor = b + 64'd3;
      end
      if (disturb && k == 11) start = 1'b0;
    end
    if (!got) begin
      check("done_timeout", 64'd0, 64'd1);
      return;
    end
    check("latency", 64'(lat), spec ? 64'd1 : 64'(W + 2));
    check("result", result, exp_r);
    check("busy_cycles", 64'(busy_n), spec ? 64'd0 : 64'(W + 1));
    check("stall_cycles", 64'(stall_n), spec ? 64'd0 : 64'(W + 1));
    if (disturb) begin
      start = 1'b1; op = OP_DIVU; dividend = 64'd999; divisor = 64'd2;
    end
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", 64'(done), 64'd0);
    check("result_hold", result, exp_r);
    if (disturb) begin
      @(negedge clk);
      check("done_cycle_start_ignored", 64'(busy), 64'd0);
    end
  endtask

  task automatic reset_mid_op();
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; dividend = 64'd123456789; divisor = 64'd11;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (30) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_result", result, 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_done", 64'(done), 64'd0);
    end
    rst = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      check("post_rst_no_done", 64'(done), 64'd0);
    end
    run_op(OP_REMU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1'b0);
  endtask

  initial begin
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  o;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; start = 1'b0; op = '0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_result", result, 64'd0);
    rst = 1'b0;

    run_op(OP_DIVU, 64'd100, 64'd7, 1'b0);
    run_op(OP_DIV,  -64'sd100, 64'd7, 1'b0);
    run_op(OP_REM,  -64'sd100, 64'd7, 1'b0);
    run_op(OP_REM,  64'd100, -64'sd7, 1'b0);
    run_op(OP_DIVU, 64'd5, 64'd0, 1'b0);
    run_op(OP_REMU, 64'd5, 64'd0, 1'b0);
    run_op(OP_DIV,  MOST_NEG, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run_op(OP_REM,  MOST_NEG, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run_op(OP_DIV,  -64'sd1000, -64'sd33, 1'b1);
    reset_mid_op();

    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: b = 64'd0;
        1: begin a = MOST_NEG; b = 64'hFFFF_FFFF_FFFF_FFFF; end
        2: b = 64'($urandom_range(1, 50));
        3: b = {{32{b[31]}}, b[31:0]};
        4: a = MOST_NEG;
        default: ;
      endcase
      run_op(o, a, b, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
